// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO with CTS flow control.
// Define UART_PARITY_EN for 8E1 framing with even-parity checking.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_MARGIN = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          uart_cts,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int BW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0] DIV_M1  = BW'(DIV - 1);
  localparam logic [BW-1:0] HALF_M1 = BW'(HALF - 1);
  localparam logic [AW:0]   CTS_TH  = (AW+1)'(FIFO_DEPTH - CTS_MARGIN - 1);
  localparam logic [AW:0]   FULL_N  = (AW+1)'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_sync;
  logic [BW-1:0]   r_baud_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic            r_cts;
  logic            r_frame_err;
  logic            r_overrun;

  logic            w_rxs;
  logic            w_tick;
  logic            w_half;
  logic            w_push;
  logic            w_ferr;
  logic [AW:0]     w_count;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_baud_cnt == DIV_M1);
  assign w_half = (r_baud_cnt == HALF_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], uart_rx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_rxs) w_next = S_START;
      S_START: if (w_half) w_next = w_rxs ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:  if (w_tick && r_bit == 3'd7) w_next = S_PAR;
      S_PAR:   if (w_tick) w_next = (w_rxs != ^r_shift) ? S_BREAK : S_STOP;
`else
      S_DATA:  if (w_tick && r_bit == 3'd7) w_next = S_STOP;
`endif
      S_STOP:  if (w_tick) w_next = w_rxs ? S_IDLE : S_BREAK;
      S_BREAK: if (w_rxs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_push = 1'b0;
    w_ferr = 1'b0;
    if (r_state == S_STOP && w_tick) begin
      w_push = w_rxs;
      w_ferr = !w_rxs;
    end
`ifdef UART_PARITY_EN
    if (r_state == S_PAR && w_tick)
      w_ferr = (w_rxs != ^r_shift);
`endif
  end

  // Counter restarts on every state change so each state times from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
    end else begin
      if (r_state != w_next || r_state == S_IDLE || r_state == S_BREAK)
        r_baud_cnt <= '0;
      else if (w_tick)
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + BW'(1);
      if (r_state != S_DATA)
        r_bit <= '0;
      else if (w_tick)
        r_bit <= r_bit + 3'd1;
      if (r_state == S_DATA && w_tick)
        r_shift <= {w_rxs, r_shift[7:1]};
    end
  end

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == FULL_N);
  assign w_pop   = rd_en && !w_empty;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cts       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      r_cts       <= (w_count <= CTS_TH);
      r_frame_err <= w_ferr;
      r_overrun   <= w_push && w_full && !w_pop;
    end
  end

  assign rd_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign empty     = w_empty;
  assign count     = w_count;
  assign uart_cts  = r_cts;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue model.
// Set UART_PARITY_EN to exercise 8E1 framing.
module tb_uart_rx_fifo;

  localparam int DIV   = 25000000 / 115200;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic [4:0] count;
  logic       uart_cts;
  logic       frame_err;
  logic       overrun;

  int checks;
  int failures;
  int fe_cnt;
  int ov_cnt;
  logic [7:0] model_q [$];

  uart_rx_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .count     (count),
    .uart_cts  (uart_cts),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    uart_rx = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_ok);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_PARITY_EN
    bit_out((^d) ^ !par_ok);
`endif
    bit_out(stop_b);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = model_q.pop_front();
    chk(tag, {24'h0, rd_data}, {24'h0, e});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic push_model(input logic [7:0] d);
    if (model_q.size() < DEPTH) model_q.push_back(d);
  endtask

  initial begin
    int lat;
    int fe0;
    int ov0;
    int ns;
    logic [7:0] d;
    checks = 0; failures = 0; fe_cnt = 0; ov_cnt = 0;
    rst = 1'b1; uart_rx = 1'b1; rd_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_count", {27'h0, count}, 32'h0);
    chk("rst_cts", {31'h0, uart_cts}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_ovr", {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("cts_after_rst", {31'h0, uart_cts}, 32'h1);

    idle(10000);
    chk("idle_fe", fe_cnt, 0);
    chk("idle_ov", ov_cnt, 0);
    chk("idle_empty", {31'h0, empty}, 32'h1);
    chk("idle_count", {27'h0, count}, 32'h0);
    chk("idle_cts", {31'h0, uart_cts}, 32'h1);

    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        while (empty && lat < 2400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    model_q.push_back(8'hA5);
    chk("a5_latency_ok", {31'h0, (lat >= 2055 && lat <= 2075)}, 32'h1);
    chk("a5_count", {27'h0, count}, 32'h1);
    pop_check("a5_data");
    chk("a5_empty_after_pop", {31'h0, empty}, 32'h1);

    fe0 = fe_cnt;
    uart_rx = 1'b0;
    repeat (50) @(negedge clk);
    idle(400);
    chk("glitch_fe", fe_cnt - fe0, 0);
    chk("glitch_empty", {31'h0, empty}, 32'h1);

    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (3 * DIV) @(negedge clk);
    idle(50);
    chk("brk_one_fe", fe_cnt - fe0, 1);
    chk("brk_count", {27'h0, count}, 32'h0);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(20);
    model_q.push_back(8'h3C);
    chk("after_brk_count", {27'h0, count}, 32'h1);
    pop_check("after_brk_data");

    ov0 = ov_cnt;
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
      idle(10);
      push_model(8'(i));
      chk("fill_cts", {31'h0, uart_cts},
          {31'h0, (model_q.size() <= DEPTH - 4 - 1)});
    end
    chk("fill_overrun", ov_cnt - ov0, 1);
    chk("fill_count", {27'h0, count}, 32'd16);
    for (int i = 0; i < 16; i++) pop_check("drain_data");
    chk("drain_empty", {31'h0, empty}, 32'h1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("pop_empty_count", {27'h0, count}, 32'h0);
    chk("pop_empty_ov", ov_cnt - ov0, 1);

    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, 1'b1);
      idle(5 + $urandom_range(0, 40));
      push_model(d);
      ns = model_q.size();
      chk("rnd_count", {27'h0, count}, ns);
      if ($urandom_range(0, 1) == 1) pop_check("rnd_data");
    end
    while (model_q.size() > 0) pop_check("rnd_drain");
    chk("rnd_empty", {31'h0, empty}, 32'h1);

`ifdef UART_PARITY_EN
    fe0 = fe_cnt;
    send_frame(8'h01, 1'b1, 1'b0);
    idle(20);
    chk("par_bad_fe", fe_cnt - fe0, 1);
    chk("par_bad_empty", {31'h0, empty}, 32'h1);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(20);
    model_q.push_back(8'h01);
    pop_check("par_good_data");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
